hilo_muldiv_ctrl: RTL
=====================

# hilo_muldiv_ctrl

Multi-cycle multiply/divide sequencer that owns the architectural HI/LO registers for the MIPS integer datapath. It accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO requests through a valid/ready handshake and runs a 32-step shift-add multiplier or restoring divider. It writes HI/LO and a zon flag vector on completion. The single-cycle ALU keeps all 32-bit ops; this block sits beside it and serves all HI/LO traffic.

## Interface
Parameters:
- `WIDTH`, 32, operand width; only 32 is supported.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_op` in 3: operation code, from the package.
- `req_a` in 32: rs operand, the dividend or multiplicand.
- `req_b` in 32: rt operand, the divisor or multiplier.
- `done` out 1: one-cycle completion pulse.
- `hi` out 32: HI register.
- `lo` out 32: LO register.
- `zon` out 3: {zero, overflow, negative}, registered at completion.
- `div0` out 1: divide-by-zero, valid with `done`.
- `op_err` out 1: reserved or disabled op, valid with `done`.

## Operation
- States: IDLE, CALC, FIX, DONE.
- Accept occurs on a rising edge with `req_valid & req_ready`.
  - Operands are latched on that edge.
  - MULT and DIV latch absolute values and record the result sign.
- MULT/MULTU: accept → CALC.
  - 32 iterations, each one conditional add plus a shift into a 64-bit accumulator.
  - FIX applies two's-complement negation when the signs differ.
- DIV/DIVU: accept → CALC.
  - 32 restoring steps.
  - FIX applies signs: quotient truncates toward zero; remainder takes the dividend's sign.
- FIX → DONE writes the result: mult gives hi=product[63:32], lo=product[31:0]; div gives lo=quotient, hi=remainder.
- DONE → IDLE unconditionally.
- Flags:
  - mult: zero = product==0; overflow = hi != sign-extension of lo[31] (MULT) or hi!=0 (MULTU); negative = hi[31] (MULT only).
  - div: zero = quotient==0; overflow only for DIV 0x80000000 / 0xFFFFFFFF, which gives lo=0x80000000, hi=0; negative = quotient[31] (DIV only).
- Divisor zero: accept → DONE directly; hi/lo unchanged, `div0`=1, zon=3'b000.
- MTHI/MTLO: accept → DONE; HI or LO = `req_a`; zon=3'b000.
- Reserved ops (3'b110, 3'b111): accept → DONE; hi/lo unchanged, `op_err`=1.
- `req_valid` while not IDLE is ignored; there is no queuing.

## Timing
- Reset values: state IDLE, hi=0, lo=0, zon=0, done=0, div0=0, op_err=0, req_ready=1.
- Reset mid-operation aborts immediately; no `done` is produced for the aborted op.
- Mult/div latency: `done` rises at the 33rd rising edge after the accepting edge.
  - hi, lo and zon update on that same edge.
  - The next accept is possible at the 34th edge.
- Short ops (MTHI, MTLO, div-by-zero, error): `done` rises at the 1st edge after accept; the next accept is possible at the 2nd edge.
- `done`, `div0` and `op_err` are high for exactly one cycle.
- `hi`/`lo` are stable from completion until the next completion.

## Configuration
- `HILO_DIV_EN` defined: the divider is present and behaves as above.
- `HILO_DIV_EN` undefined: divider logic is removed.
  - DIV/DIVU take the reserved-op path: `done` 1 edge after accept, `op_err`=1, hi/lo unchanged.
  - Multiply behaviour is identical.

## Structure
- The shared package holds:
  - op codes: MULT=3'b000, MULTU=001, DIV=010, DIVU=011, MTHI=100, MTLO=101.
  - the state enum.
  - zon bit index constants (ZON_Z=2, ZON_O=1, ZON_N=0).
- One sub-module, `hilo_iter_step`: a combinational single iteration with mode select, covering the add-shift step and the subtract/restore step.
- FSM, counter, sign handling and HI/LO registers stay in the top.

## Test plan
- MULT a=0xFFFFFFFD, b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB, zon=3'b001, `done` 33 edges after accept.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001, zon=3'b010.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF, zon=3'b001.
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0, zon=3'b011.
- DIVU a=100, b=0 with hi/lo preloaded by MTHI 0x12345678 / MTLO 0x9ABCDEF0 → `done`+`div0` 1 edge after accept; hi/lo unchanged.
- MULT accepted, then `rst` pulsed on CALC cycle 10 → hi=lo=0, `req_ready`=1 immediately, no `done`; the next MULT 3×4 gives lo=12.
- `req_valid` held high across a MULT → only one accept; a second accept occurs at the 34th edge, checked against `req_ready`.
  - Op 3'b111 → `op_err` pulse, hi/lo unchanged.

Source files
------------

// File: rtl/hilo_muldiv_ctrl_pkg.sv
// hilo_muldiv_ctrl_pkg: shared definitions for the HI/LO multiply/divide sequencer.
//   op_e    : request op codes (3'b110 and 3'b111 are reserved)
//   state_e : sequencer states
//   ZON_*   : bit positions inside the {zero, overflow, negative} flag vector
package hilo_muldiv_ctrl_pkg;
  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX, ST_DONE} state_e;

  localparam int ZON_Z = 2;
  localparam int ZON_O = 1;
  localparam int ZON_N = 0;
endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// hilo_muldiv_ctrl_if: request handshake plus HI/LO result bus.
//   master : requester (drives req_valid/req_op/req_a/req_b)
//   slave  : sequencer (drives req_ready, done, hi, lo, zon, div0, op_err)
interface hilo_muldiv_ctrl_if #(parameter int WIDTH = 32);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [2:0]       zon;
  logic             div0;
  logic             op_err;

  modport master (output req_valid, req_op, req_a, req_b,
                  input  req_ready, done, hi, lo, zon, div0, op_err);
  modport slave  (input  req_valid, req_op, req_a, req_b,
                  output req_ready, done, hi, lo, zon, div0, op_err);
endinterface

// File: rtl/hilo_muldiv_ctrl_iter_step.sv
// hilo_iter_step: one combinational iteration of the shift-add multiplier or
// the restoring divider, both working on a 2*WIDTH accumulator.
//   div_mode : 0 = multiply step, 1 = divide step
//   acc_in   : mult {partial_hi, multiplier}; div {remainder, dividend/quotient}
//   opnd     : multiplicand (mult) or divisor (div)
//   acc_out  : accumulator after the step
// Macro HILO_DIV_EN: when undefined the divide step is not built.
module hilo_iter_step #(parameter int WIDTH = 32) (
  input  logic               div_mode,
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_out
);
  logic [WIDTH:0] sum;
`ifdef HILO_DIV_EN
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;
`endif

  always_comb begin
    // Multiply: add multiplicand when the multiplier LSB is set, then shift
    // the 65-bit {carry, partial} right by one into the accumulator.
    sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, opnd} : '0);
    acc_out = {sum, acc_in[WIDTH-1:1]};
`ifdef HILO_DIV_EN
    // Restoring divide: shift {rem, quo} left, trial-subtract the divisor.
    // rem_sh keeps the bit shifted out of the remainder so the compare is exact.
    rem_sh = acc_in[2*WIDTH-1:WIDTH-1];
    ge     = rem_sh >= {1'b0, opnd};
    diff   = rem_sh[WIDTH-1:0] - opnd;
    if (div_mode)
      acc_out = ge ? {diff, acc_in[WIDTH-2:0], 1'b1}
                   : {rem_sh[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
`endif
  end

`ifndef HILO_DIV_EN
  logic unused_div_mode;
  assign unused_div_mode = div_mode;
`endif
endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO,
// plus single-cycle MTHI/MTLO writes.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of hilo_muldiv_ctrl_if (request handshake, HI/LO,
//              zon flags, done/div0/op_err pulses)
// Macro HILO_DIV_EN: defined = divider present; undefined = DIV/DIVU complete
// through the reserved-op path with op_err.
// Results are committed on the DONE->IDLE edge, so done, hi, lo and zon change
// together. The first iteration runs on the accepting edge straight from the
// request operands, which is what gives the 33-edge completion.
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  hilo_muldiv_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef HILO_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
  logic [2:0]         op_q, op_d, zon_q, zon_d;
  logic qneg_q, qneg_d, rneg_q, rneg_d, ovf_q, ovf_d, div0p_q, div0p_d;
  logic done_q, done_d, div0_q, div0_d, err_q, err_d;

  logic               req_signed, req_mul, req_div, op_is_div, step_div;
  logic [WIDTH-1:0]   abs_a, abs_b, step_opnd, q_res, r_res;
  logic [2*WIDTH-1:0] step_acc, step_out;

  hilo_iter_step #(.WIDTH(WIDTH)) u_step (
    .div_mode(step_div), .acc_in(step_acc), .opnd(step_opnd), .acc_out(step_out)
  );

  always_comb begin
    req_signed = (bus.req_op == OP_MULT) || (bus.req_op == OP_DIV);
    req_mul    = (bus.req_op == OP_MULT) || (bus.req_op == OP_MULTU);
    req_div    = DIV_EN && ((bus.req_op == OP_DIV) || (bus.req_op == OP_DIVU));
    abs_a      = (req_signed && bus.req_a[WIDTH-1]) ? -bus.req_a : bus.req_a;
    abs_b      = (req_signed && bus.req_b[WIDTH-1]) ? -bus.req_b : bus.req_b;
    op_is_div  = (op_q == OP_DIV) || (op_q == OP_DIVU);
    q_res      = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    r_res      = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    // In IDLE the step unit sees the incoming operands (first iteration).
    if (state_q == ST_IDLE) begin
      step_div  = req_div;
      step_acc  = {{WIDTH{1'b0}}, req_div ? abs_a : abs_b};
      step_opnd = req_div ? abs_b : abs_a;
    end else begin
      step_div  = op_is_div;
      step_acc  = acc_q;
      step_opnd = opnd_q;
    end
  end

  always_comb begin
    state_d = state_q;  cnt_d  = cnt_q;  acc_d  = acc_q;  opnd_d = opnd_q;
    op_d    = op_q;     qneg_d = qneg_q; rneg_d = rneg_q; ovf_d  = ovf_q;
    div0p_d = div0p_q;  hi_d   = hi_q;   lo_d   = lo_q;   zon_d  = zon_q;
    done_d  = 1'b0;     div0_d = 1'b0;   err_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: if (bus.req_valid) begin
        op_d    = bus.req_op;
        qneg_d  = req_signed && (bus.req_a[WIDTH-1] ^ bus.req_b[WIDTH-1]);
        rneg_d  = (bus.req_op == OP_DIV) && bus.req_a[WIDTH-1];
        ovf_d   = (bus.req_op == OP_DIV) && (bus.req_a == MIN_NEG) && (&bus.req_b);
        div0p_d = req_div && (bus.req_b == '0);
        if (req_mul || (req_div && (bus.req_b != '0))) begin
          acc_d   = step_out;
          opnd_d  = step_opnd;
          cnt_d   = CW'(1);
          state_d = ST_CALC;
        end else begin
          // Short ops: MTHI/MTLO payload parks in acc until commit.
          acc_d   = {{WIDTH{1'b0}}, bus.req_a};
          state_d = ST_DONE;
        end
      end
      ST_CALC: begin
        acc_d = step_out;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        acc_d   = op_is_div ? {r_res, q_res} : (qneg_q ? -acc_q : acc_q);
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        zon_d   = '0;
        if ((op_q == OP_MULT) || (op_q == OP_MULTU)) begin
          hi_d = acc_q[2*WIDTH-1:WIDTH];
          lo_d = acc_q[WIDTH-1:0];
          zon_d[ZON_Z] = (acc_q == '0);
          zon_d[ZON_O] = (op_q == OP_MULT)
                         ? (acc_q[2*WIDTH-1:WIDTH] != {WIDTH{acc_q[WIDTH-1]}})
                         : (acc_q[2*WIDTH-1:WIDTH] != '0);
          zon_d[ZON_N] = (op_q == OP_MULT) && acc_q[2*WIDTH-1];
        end else if (op_is_div && DIV_EN) begin
          if (div0p_q) div0_d = 1'b1;
          else begin
            hi_d = acc_q[2*WIDTH-1:WIDTH];
            lo_d = acc_q[WIDTH-1:0];
            zon_d[ZON_Z] = (acc_q[WIDTH-1:0] == '0);
            zon_d[ZON_O] = ovf_q;
            zon_d[ZON_N] = (op_q == OP_DIV) && acc_q[WIDTH-1];
          end
        end else if (op_q == OP_MTHI) hi_d = acc_q[WIDTH-1:0];
        else if (op_q == OP_MTLO) lo_d = acc_q[WIDTH-1:0];
        else err_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE; cnt_q <= '0;  acc_q <= '0;  opnd_q <= '0;
      op_q <= '0;  qneg_q <= 1'b0; rneg_q <= 1'b0; ovf_q <= 1'b0;
      div0p_q <= 1'b0; hi_q <= '0; lo_q <= '0; zon_q <= '0;
      done_q <= 1'b0; div0_q <= 1'b0; err_q <= 1'b0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; acc_q <= acc_d; opnd_q <= opnd_d;
      op_q <= op_d; qneg_q <= qneg_d; rneg_q <= rneg_d; ovf_q <= ovf_d;
      div0p_q <= div0p_d; hi_q <= hi_d; lo_q <= lo_d; zon_q <= zon_d;
      done_q <= done_d; div0_q <= div0_d; err_q <= err_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.zon       = zon_q;
  assign bus.div0      = div0_q;
  assign bus.op_err    = err_q;
endmodule
